// File: rtl/hsv_core_pkg.sv
// Shared core types: register-file addressing, data words and writeback request payloads.
// Writeback port indices follow wb_port_e; arbiters size their request vectors from WB_PORTS.
package hsv_core_pkg;

    typedef logic [4:0]  reg_addr;
    typedef logic [31:0] word;
    typedef logic [31:0] reg_mask;

    localparam int WB_PORTS = 4;

    typedef enum logic [1:0] {
        WB_ALU         = 2'd0,
        WB_BRANCH      = 2'd1,
        WB_CTRL_STATUS = 2'd2,
        WB_MEM         = 2'd3
    } wb_port_e;

    typedef struct packed {
        reg_addr rd_addr;
        word     rd_data;
        logic    rd_we;
    } wb_req_t;

endpackage

// File: rtl/hsv_core_wb_rr_picker.sv
// Rotating-priority picker: grants the first valid requester at or after ptr_i, wrapping modulo NUM_PORTS.
// Purely combinational, zero latency; never grants an invalid requester.
// No backpressure of its own; the caller decides whether the pick becomes a transfer.
module hsv_core_wb_rr_picker #(
    parameter int NUM_PORTS = 4,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_PORTS-1:0] valid_i,
    input  logic [PTR_W-1:0]     ptr_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [PTR_W-1:0]     idx_o,
    output logic                 any_o
);

    always_comb begin
        int cand;
        grant_o = '0;
        idx_o   = '0;
        any_o   = |valid_i;
        cand    = 0;
        // Walk from the farthest offset back to the pointer so the nearest valid port wins.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand = (int'(ptr_i) + k) % NUM_PORTS;
            if (valid_i[cand]) begin
                grant_o       = '0;
                grant_o[cand] = 1'b1;
                idx_o         = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/hsv_core_wb_arbiter.sv
// Writeback arbiter: shares the register-file write port among the exec ports (round-robin when
// HSV_WB_ROUND_ROBIN_EN is defined, else fixed lowest-index priority). Transfer in cycle N -> wr_* in N+1.
// Backpressure: one grant per cycle via req_ready_o; flush_req withholds every grant.
module hsv_core_wb_arbiter
    import hsv_core_pkg::*;
#(
    parameter int NUM_PORTS = WB_PORTS
) (
    input  logic                 clk_core,
    input  logic                 rst_core_n,
    input  logic                 flush_req,
    output logic                 flush_ack,
    input  logic [NUM_PORTS-1:0] req_valid_i,
    output logic [NUM_PORTS-1:0] req_ready_o,
    input  wb_req_t              req_i [NUM_PORTS],
    output logic [4:0]           wr_addr,
    output logic [31:0]          wr_data,
    output logic                 wr_en,
    output logic [31:0]          commit_mask
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0] pick_grant;
    logic [PTR_W-1:0]     pick_idx;
    logic [PTR_W-1:0]     pick_ptr;
    logic                 pick_any;
    logic                 xfer;
    wb_req_t              sel;

    logic    flush_ack_q, flush_ack_d;
    logic    wr_en_q, wr_en_d;
    reg_addr wr_addr_q, wr_addr_d;
    word     wr_data_q, wr_data_d;
    reg_mask commit_mask_q, commit_mask_d;

`ifdef HSV_WB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] prio_ptr_q, prio_ptr_d;

    always_comb begin
        prio_ptr_d = prio_ptr_q;
        if (flush_req) begin
            prio_ptr_d = '0;
        end else if (xfer) begin
            prio_ptr_d = (int'(pick_idx) == NUM_PORTS - 1) ? '0 : pick_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            prio_ptr_q <= '0;
        end else begin
            prio_ptr_q <= prio_ptr_d;
        end
    end

    assign pick_ptr = prio_ptr_q;
`else
    assign pick_ptr = '0;
`endif

    hsv_core_wb_rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_picker (
        .valid_i (req_valid_i),
        .ptr_i   (pick_ptr),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        xfer        = pick_any & ~flush_req;
        req_ready_o = xfer ? pick_grant : '0;
        sel         = req_i[pick_idx];

        flush_ack_d = flush_req;
        // x0 and non-writing results are consumed but must not touch the register file or hazards.
        wr_en_d       = xfer & sel.rd_we & (sel.rd_addr != '0);
        wr_addr_d     = xfer ? sel.rd_addr : wr_addr_q;
        wr_data_d     = xfer ? sel.rd_data : wr_data_q;
        commit_mask_d = wr_en_d ? (reg_mask'(1) << sel.rd_addr) : '0;
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            flush_ack_q   <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            commit_mask_q <= '0;
        end else begin
            flush_ack_q   <= flush_ack_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            commit_mask_q <= commit_mask_d;
        end
    end

    assign flush_ack   = flush_ack_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign commit_mask = commit_mask_q;

endmodule
